// File: rtl/datapacket_pkg.sv
// Shared definitions for the sensor datapacket UART link (transmitter and ground receiver).
package datapacket_pkg;

  localparam int         PKT_W             = 48;
  localparam int         PKT_BYTES         = 6;
  localparam int         FRAME_BYTES       = 8;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PAYLOAD,
    ST_CSUM,
    ST_DONE
  } framer_state_t;

  // Payload byte by index; index 0 is the most significant byte, sent first.
  function automatic logic [7:0] payloadByte(input logic [PKT_W-1:0] pkt,
                                             input logic [2:0]       idx);
    logic [7:0] result;
    case (idx)
      3'd0:    result = pkt[47:40];
      3'd1:    result = pkt[39:32];
      3'd2:    result = pkt[31:24];
      3'd3:    result = pkt[23:16];
      3'd4:    result = pkt[15:8];
      3'd5:    result = pkt[7:0];
      default: result = 8'h00;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/datapacket_uart_tx_byte.sv
// 8N1 byte serializer; accepts a new byte in the last cycle of the stop bit so bytes run gap-free.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       SYSCLK,
  input  logic       SYSRESET,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       tx,
  output logic       byte_done
);

  localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);

  logic          r_active;
  logic [9:0]    r_shift;
  logic [CW-1:0] r_clkCnt;
  logic [3:0]    r_bitIdx;
  logic          w_bitEnd;

  assign w_bitEnd   = (r_clkCnt == LAST_CLK);
  assign byte_done  = r_active && w_bitEnd && (r_bitIdx == 4'd9);
  assign byte_ready = !r_active || byte_done;
  assign tx         = r_active ? r_shift[0] : 1'b1;

  // Load {stop, data, start} on handshake, then shift one bit every CLKS_PER_BIT cycles.
  always_ff @(posedge SYSCLK or posedge SYSRESET) begin
    if (SYSRESET) begin
      r_active <= 1'b0;
      r_shift  <= '1;
      r_clkCnt <= '0;
      r_bitIdx <= '0;
    end else if (byte_valid && byte_ready) begin
      r_active <= 1'b1;
      r_shift  <= {1'b1, byte_in, 1'b0};
      r_clkCnt <= '0;
      r_bitIdx <= '0;
    end else if (r_active) begin
      if (w_bitEnd) begin
        r_clkCnt <= '0;
        if (r_bitIdx == 4'd9) begin
          r_active <= 1'b0;
        end else begin
          r_bitIdx <= r_bitIdx + 4'd1;
          r_shift  <= {1'b1, r_shift[9:1]};
        end
      end else begin
        r_clkCnt <= r_clkCnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/datapacket_uart_tx.sv
// Frames a 48-bit datapacket as SYNC + 6 payload bytes + XOR checksum and sends it as 8N1 UART.
module datapacket_uart_tx
  import datapacket_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 87,
  parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
  input  logic             SYSCLK,
  input  logic             SYSRESET,
  input  logic [PKT_W-1:0] datapacket,
  input  logic             pkt_valid,
  output logic             pkt_ready,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);

  framer_state_t    r_state, w_nextState;
  logic [PKT_W-1:0] r_hold;
  logic [7:0]       r_csum;
  logic [2:0]       r_byteIdx;

  logic       w_accept;
  logic       w_byteValid;
  logic [7:0] w_byteIn;
  logic       w_byteReady;
  logic       w_byteDone;
  logic       w_loadPayload;

  assign pkt_ready  = (r_state == ST_IDLE) && w_byteReady && !SYSRESET;
  assign w_accept   = pkt_valid && pkt_ready;
  assign busy       = (r_state != ST_IDLE);
  assign frame_done = (r_state == ST_DONE);

  // Framer state register.
  always_ff @(posedge SYSCLK or posedge SYSRESET) begin
    if (SYSRESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; the following byte is handed to the serializer in the same cycle the current one ends.
  always_comb begin
    w_nextState   = r_state;
    w_byteValid   = 1'b0;
    w_byteIn      = SYNC_BYTE;
    w_loadPayload = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_nextState = ST_SYNC;
          w_byteValid = 1'b1;
          w_byteIn    = SYNC_BYTE;
        end
      end
      ST_SYNC: begin
        if (w_byteDone) begin
          w_nextState   = ST_PAYLOAD;
          w_byteValid   = 1'b1;
          w_byteIn      = payloadByte(r_hold, 3'd0);
          w_loadPayload = 1'b1;
        end
      end
      ST_PAYLOAD: begin
        if (w_byteDone) begin
          w_byteValid = 1'b1;
          if (r_byteIdx == 3'(PKT_BYTES - 1)) begin
            w_nextState = ST_CSUM;
            w_byteIn    = r_csum;
          end else begin
            w_byteIn      = payloadByte(r_hold, r_byteIdx + 3'd1);
            w_loadPayload = 1'b1;
          end
        end
      end
      ST_CSUM: begin
        if (w_byteDone) begin
          w_nextState = ST_DONE;
        end
      end
      ST_DONE: begin
        w_nextState = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Holding register, running checksum and payload byte index.
  always_ff @(posedge SYSCLK or posedge SYSRESET) begin
    if (SYSRESET) begin
      r_hold    <= '0;
      r_csum    <= '0;
      r_byteIdx <= '0;
    end else begin
      if (w_accept) begin
        r_hold <= datapacket;
        r_csum <= '0;
      end
      if (w_loadPayload) begin
        r_csum <= r_csum ^ w_byteIn;
      end
      if ((r_state == ST_SYNC) && w_byteDone) begin
        r_byteIdx <= '0;
      end else if ((r_state == ST_PAYLOAD) && w_byteDone) begin
        r_byteIdx <= r_byteIdx + 3'd1;
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byteTx (
    .SYSCLK    (SYSCLK),
    .SYSRESET  (SYSRESET),
    .byte_in   (w_byteIn),
    .byte_valid(w_byteValid),
    .byte_ready(w_byteReady),
    .tx        (tx),
    .byte_done (w_byteDone)
  );

endmodule

// File: tb/tb_datapacket_uart_tx.sv
// Self-checking bench for datapacket_uart_tx: table vectors, corner sequences and random packets.
module tb_datapacket_uart_tx;
  import datapacket_pkg::*;

  localparam int CPB       = 4;
  localparam int FRAME_CYC = 10 * FRAME_BYTES * CPB;

  typedef struct {
    logic [47:0] pkt;
    logic [7:0]  csum;
  } vec_t;

  logic        SYSCLK = 1'b0;
  logic        SYSRESET;
  logic [47:0] datapacket;
  logic        pkt_valid;
  logic        pkt_ready;
  logic        tx;
  logic        busy;
  logic        frame_done;

  int checks = 0;
  int passes = 0;

  // 10 ns clock period.
  always #5 SYSCLK = ~SYSCLK;

  datapacket_uart_tx #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .SYSCLK    (SYSCLK),
    .SYSRESET  (SYSRESET),
    .datapacket(datapacket),
    .pkt_valid (pkt_valid),
    .pkt_ready (pkt_ready),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  // One comparison: counts it, and prints a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference: XOR of the six payload bytes.
  function automatic logic [7:0] modelCsum(input logic [47:0] pkt);
    logic [7:0] c = 8'h00;
    for (int i = 0; i < 6; i++) c ^= pkt[8*i +: 8];
    return c;
  endfunction

  // Reference: byte j of the frame (0 = sync, 1..6 = payload MSB first, 7 = checksum).
  function automatic logic [7:0] modelByte(input logic [47:0] pkt, input logic [7:0] csum, input int j);
    if (j == 0) return 8'hA5;
    if (j == 7) return csum;
    return pkt[8*(6-j) +: 8];
  endfunction

  // Reference: UART bit n of the frame (start 0, LSB-first data, stop 1 per byte).
  function automatic logic modelBit(input logic [47:0] pkt, input logic [7:0] csum, input int n);
    int         b = n % 10;
    logic [7:0] v = modelByte(pkt, csum, n / 10);
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return v[b-1];
  endfunction

  // Present a packet and wait (bounded) for the accepting clock edge.
  task automatic applyStimulus(input logic [47:0] pkt);
    int waitCyc = 0;
    datapacket = pkt;
    pkt_valid  = 1'b1;
    while (!pkt_ready && waitCyc < 1000) begin
      @(negedge SYSCLK);
      waitCyc++;
    end
    checkOutput("accept wait", pkt_ready, 1'b1);
    if (pkt_ready) @(posedge SYSCLK);
  endtask

  // Sample every frame cycle, check bit timing, decode bytes, then check the DONE cycle.
  task automatic receiveFrame(input logic [47:0] pkt, input logic [7:0] csum, input string name,
                              input bit changeData, input bit holdValid, input bit pulseBusy);
    logic       samp[FRAME_CYC];
    int         errs = 0;
    logic [7:0] got;
    for (int k = 0; k < FRAME_CYC; k++) begin
      @(negedge SYSCLK);
      samp[k] = tx;
      if (tx !== modelBit(pkt, csum, k / CPB) || frame_done !== 1'b0 ||
          busy !== 1'b1 || pkt_ready !== 1'b0) errs++;
      if (k == 0) begin
        if (!holdValid) pkt_valid = 1'b0;
        if (changeData) datapacket = '1;
      end
      if (pulseBusy && k == 50) begin
        datapacket = 48'hDEADBEEF0000;
        pkt_valid  = 1'b1;
      end
      if (pulseBusy && k == 51) pkt_valid = 1'b0;
    end
    checkOutput({name, " cycle timing errors"}, errs, 0);
    for (int j = 0; j < FRAME_BYTES; j++) begin
      got = 8'h00;
      for (int b = 0; b < 8; b++) got[b] = samp[(j*10 + 1 + b)*CPB + CPB/2];
      checkOutput($sformatf("%s byte %0d", name, j), got, modelByte(pkt, csum, j));
    end
    @(negedge SYSCLK);
    checkOutput({name, " done pulse"}, frame_done, 1'b1);
    checkOutput({name, " done tx"}, tx, 1'b1);
    checkOutput({name, " done busy"}, busy, 1'b1);
    checkOutput({name, " done ready"}, pkt_ready, 1'b0);
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t        vecs[4];
    logic [47:0] rp;
    int          errs;

    vecs[0] = '{pkt: 48'h0123456789AB, csum: 8'h22};
    vecs[1] = '{pkt: 48'h112233445566, csum: 8'h77};
    vecs[2] = '{pkt: 48'hDEADBEEF0000, csum: 8'h22};
    vecs[3] = '{pkt: 48'hFFFFFFFFFFFF, csum: 8'h00};

    // Reset held for five cycles.
    SYSRESET   = 1'b1;
    pkt_valid  = 1'b0;
    datapacket = '0;
    repeat (5) @(negedge SYSCLK);
    checkOutput("reset tx", tx, 1'b1);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset frame_done", frame_done, 1'b0);
    checkOutput("reset pkt_ready", pkt_ready, 1'b0);
    SYSRESET = 1'b0;
    @(negedge SYSCLK);
    checkOutput("post-reset pkt_ready", pkt_ready, 1'b1);
    checkOutput("post-reset busy", busy, 1'b0);
    checkOutput("post-reset tx", tx, 1'b1);

    // Table-driven frames with hand-computed checksums.
    for (int v = 0; v < 4; v++) begin
      applyStimulus(vecs[v].pkt);
      receiveFrame(vecs[v].pkt, vecs[v].csum, $sformatf("vec%0d", v), 1'b0, 1'b0, 1'b0);
    end

    // Capture isolation: input changes right after acceptance.
    applyStimulus(48'h0123456789AB);
    receiveFrame(48'h0123456789AB, 8'h22, "capture", 1'b1, 1'b0, 1'b0);

    // Back-to-back with pkt_valid held high.
    applyStimulus(48'h000000000000);
    receiveFrame(48'h000000000000, 8'h00, "b2b first", 1'b1, 1'b1, 1'b0);
    @(negedge SYSCLK);
    checkOutput("b2b idle tx", tx, 1'b1);
    checkOutput("b2b idle ready", pkt_ready, 1'b1);
    checkOutput("b2b idle frame_done", frame_done, 1'b0);
    @(posedge SYSCLK);
    receiveFrame(48'hFFFFFFFFFFFF, 8'h00, "b2b second", 1'b0, 1'b0, 1'b0);

    // pkt_valid pulsed while busy must be ignored.
    applyStimulus(48'h112233445566);
    receiveFrame(48'h112233445566, 8'h77, "busy ignore", 1'b0, 1'b0, 1'b1);
    @(negedge SYSCLK);
    checkOutput("busy ignore ready after done", pkt_ready, 1'b1);
    errs = 0;
    repeat (6) begin
      @(negedge SYSCLK);
      if (busy !== 1'b0 || tx !== 1'b1) errs++;
    end
    checkOutput("busy ignore no extra frame", errs, 0);

    // Reset during payload byte 3 (frame byte 4), in its start bit.
    applyStimulus(48'h0123456789AB);
    for (int k = 0; k <= 160; k++) begin
      @(negedge SYSCLK);
      if (k == 0) pkt_valid = 1'b0;
    end
    checkOutput("pre-reset start bit", tx, 1'b0);
    #2 SYSRESET = 1'b1;
    #1;
    checkOutput("mid-reset tx async", tx, 1'b1);
    checkOutput("mid-reset busy", busy, 1'b0);
    checkOutput("mid-reset ready", pkt_ready, 1'b0);
    errs = 0;
    repeat (4) begin
      @(negedge SYSCLK);
      if (frame_done !== 1'b0 || tx !== 1'b1) errs++;
    end
    SYSRESET = 1'b0;
    repeat (3) begin
      @(negedge SYSCLK);
      if (frame_done !== 1'b0 || tx !== 1'b1) errs++;
    end
    checkOutput("mid-reset no frame_done", errs, 0);
    applyStimulus(48'h112233445566);
    receiveFrame(48'h112233445566, 8'h77, "after reset", 1'b0, 1'b0, 1'b0);

    // Random packets checked against the reference model.
    for (int r = 0; r < 6; r++) begin
      rp[47:32] = 16'($urandom);
      rp[31:0]  = $urandom;
      applyStimulus(rp);
      receiveFrame(rp, modelCsum(rp), $sformatf("rand%0d", r), 1'b0, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/datapacket_uart_tx.md
Name: datapacket_uart_tx

Overview:
Consumer end of the 48-bit sensor datapacket bus driven by dummy_state and its successors. Accepts one packet per valid/ready handshake and frames it as sync + 6 payload bytes + XOR checksum. Sends the frame as 8N1 UART on a single tx line to the ground/telemetry link. Runs on the 10 MHz system clock.

Parameters:
CLKS_PER_BIT, 87, SYSCLK cycles per UART bit (10 MHz / 115200 ≈ 87); legal range ≥ 2
SYNC_BYTE, 8'hA5, first byte of every frame

Ports:
SYSCLK  in  1  system clock, all logic on rising edge
SYSRESET  in  1  reset, asynchronous, active-high
datapacket  in  48  packet from producer; sampled only on handshake
pkt_valid  in  1  producer has a packet on datapacket
pkt_ready  out  1  block can accept a packet this cycle
tx  out  1  UART serial out, idle high
busy  out  1  high from acceptance through the last stop bit
frame_done  out  1  one-cycle pulse after the last stop bit of a frame

Behaviour:
- Reset (async, SYSRESET=1): tx=1, pkt_ready=0 while reset is asserted, busy=0, frame_done=0. All counters and state are cleared. First cycle after release: pkt_ready=1.
- Handshake: a transfer occurs on a rising edge with pkt_valid&&pkt_ready. datapacket is captured into a 48-bit holding register that edge. Later changes on datapacket are ignored until the next transfer.
- pkt_ready=1 only in IDLE. busy = !IDLE.
- Frame, in order: SYNC_BYTE, datapacket[47:40], [39:32], [31:24], [23:16], [15:8], [7:0], then CSUM = XOR of the 6 payload bytes.
- Byte format: start bit 0, data LSB first, one stop bit 1. Each bit is held exactly CLKS_PER_BIT cycles. No idle gap between bytes.
- Latency: start bit of SYNC appears on tx the cycle after acceptance. Frame length is exactly 80*CLKS_PER_BIT cycles.
- Framer FSM:
  - IDLE -> SYNC on transfer.
  - SYNC -> PAYLOAD on byte complete.
  - PAYLOAD (byte index 0..5; 3-bit counter, increments on byte complete) -> CSUM after index 5 completes.
  - CSUM -> DONE on byte complete.
  - DONE -> IDLE after one cycle.
- frame_done=1 in the DONE cycle. That cycle tx=1, busy=1, pkt_ready=0. pkt_ready returns the following cycle.
- Back-to-back: with pkt_valid held high, the next packet is accepted in the first IDLE cycle. Minimum spacing between frames is one idle-high cycle after the stop bit plus the DONE cycle.
- Checksum is accumulated byte-by-byte as payload bytes are loaded. It is not recomputed from datapacket.
- Reset mid-frame: tx goes to 1 immediately, the partial frame is abandoned, and no frame_done is issued.
- pkt_valid while busy: ignored; no overrun state.
- Bit-timing counter: width $clog2(CLKS_PER_BIT). Counts 0..CLKS_PER_BIT-1 and wraps on bit advance. Bit index counts 0..9 (start, 8 data, stop).

Decomposition:
- Shared package datapacket_pkg:
  - PKT_W=48
  - PKT_BYTES=6
  - FRAME_BYTES=8
  - default SYNC_BYTE
  - framer state encoding (IDLE, SYNC, PAYLOAD, CSUM, DONE)
- The same package is reused by the future ground-side receiver.
- One sub-module, uart_tx_byte (parameter CLKS_PER_BIT):
  - ports SYSCLK, SYSRESET, byte_in[7:0], byte_valid, byte_ready, tx, byte_done
  - byte_done pulses in the last cycle of the stop bit
  - the framer presents the next byte in the same cycle, so there is no gap
- Top-level datapacket_uart_tx contains the framer FSM, holding register and checksum.

Test Plan:
1. Reset: SYSRESET=1 for 5 cycles, then release -> tx=1, busy=0, frame_done=0 during reset; pkt_ready=1 on the first cycle after release.
2. Single frame, CLKS_PER_BIT=4, datapacket=48'h0123456789AB -> UART-decoded bytes A5 01 23 45 67 89 AB 22; start bit one cycle after handshake; frame_done exactly 320 cycles after the start-bit cycle; SYNC bits on tx = 0,1,0,1,0,0,1,0,1,1.
3. Capture isolation: change datapacket to 48'hFFFFFFFFFFFF one cycle after acceptance -> frame still 01..AB with CSUM 22.
4. Back-to-back: pkt_valid held high with packets 48'h0 then 48'hFFFFFFFFFFFF -> frames A5 00×6 00 then A5 FF×6 00; exactly one idle-high cycle plus the DONE cycle between them.
5. Mid-frame reset: assert SYSRESET during payload byte 3 -> tx=1 in the same cycle (async), no frame_done; after release a new packet 48'h112233445566 sends a clean frame with CSUM 0x77.
6. Busy ignore: pulse pkt_valid with 48'hDEADBEEF0000 while busy -> not transmitted; pkt_ready stays 0 until DONE+1.
